// File: rtl/debounce_sync.sv
// Synchronises a raw asynchronous level into clk, then accepts a new level only
// after STABLE_CYCLES consecutive matching samples; emits one-cycle edge strobes.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    output logic Y,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);
    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {ST_LO, PEND_HI, ST_HI, PEND_LO} state_t;
    localparam state_t RST_STATE = RESET_LEVEL ? ST_HI : ST_LO;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_y, r_rise, r_fall, r_busy;

    state_t                 w_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_y_nxt, w_rise_nxt, w_fall_nxt, w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], A};
    end

    // A sample that returns to the stable level always aborts, even on the
    // edge that would otherwise have completed qualification.
    always_comb begin
        w_nxt      = r_state;
        w_cnt_nxt  = r_cnt;
        w_y_nxt    = r_y;
        w_rise_nxt = 1'b0;
        w_fall_nxt = 1'b0;
        case (r_state)
            ST_LO: if (w_s) begin
                w_nxt     = PEND_HI;
                w_cnt_nxt = CW'(1);
            end
            PEND_HI: begin
                if (!w_s) begin
                    w_nxt     = ST_LO;
                    w_cnt_nxt = '0;
                end else if (r_cnt == LAST) begin
                    w_nxt      = ST_HI;
                    w_y_nxt    = 1'b1;
                    w_rise_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HI: if (!w_s) begin
                w_nxt     = PEND_LO;
                w_cnt_nxt = CW'(1);
            end
            PEND_LO: begin
                if (w_s) begin
                    w_nxt     = ST_HI;
                    w_cnt_nxt = '0;
                end else if (r_cnt == LAST) begin
                    w_nxt      = ST_LO;
                    w_y_nxt    = 1'b0;
                    w_fall_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt     = RST_STATE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
            r_y     <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_y     <= w_y_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= (w_nxt == PEND_HI) || (w_nxt == PEND_LO);
        end
    end

    assign Y    = r_y;
    assign RISE = r_rise;
    assign FALL = r_fall;
    assign BUSY = r_busy;
endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: a default instance and a RESET_LEVEL=1 / short-filter
// instance, each checked every cycle against a sliding-window model.
module tb_debounce_sync;
    logic clk;
    logic rst0, A0, Y0, RISE0, FALL0, BUSY0;
    logic rst1, A1, Y1, RISE1, FALL1, BUSY1;

    int n_vec = 0;
    int n_err = 0;
    int nstrobe1 = 0;

    debounce_sync dut0 (
        .clk(clk), .rst(rst0), .A(A0), .Y(Y0), .RISE(RISE0), .FALL(FALL0), .BUSY(BUSY0)
    );
    debounce_sync #(.SYNC_STAGES(3), .STABLE_CYCLES(3), .RESET_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .A(A1), .Y(Y1), .RISE(RISE1), .FALL(FALL1), .BUSY(BUSY1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: s is A delayed by the sync depth; Y flips when the last
    // STABLE_CYCLES samples of s all disagree with Y; busy while s disagrees.
    bit dl  [2][16];
    bit win [2][16];
    bit my [2], mr [2], mf [2], mb [2];

    task automatic mreset(input int k, input bit rl);
        for (int i = 0; i < 16; i++) begin
            dl[k][i]  = rl;
            win[k][i] = rl;
        end
        my[k] = rl; mr[k] = 0; mf[k] = 0; mb[k] = 0;
    endtask

    task automatic mstep(input int k, input bit a, input int ss, input int sc);
        bit s, alld;
        s = dl[k][ss-1];
        for (int i = 15; i > 0; i--) dl[k][i] = dl[k][i-1];
        dl[k][0] = a;
        for (int i = 15; i > 0; i--) win[k][i] = win[k][i-1];
        win[k][0] = s;
        alld = 1;
        for (int i = 0; i < sc; i++) if (win[k][i] == my[k]) alld = 0;
        mr[k] = 0; mf[k] = 0;
        if (alld) begin
            my[k] = !my[k];
            mr[k] = my[k];
            mf[k] = !my[k];
        end
        mb[k] = (s != my[k]);
    endtask

    always @(posedge clk or posedge rst0)
        if (rst0) mreset(0, 1'b0); else mstep(0, A0, 2, 8);
    always @(posedge clk or posedge rst1)
        if (rst1) mreset(1, 1'b1); else mstep(1, A1, 3, 3);

    task automatic cmp(input int k, input logic y, r, f, b);
        n_vec++;
        if ({y, r, f, b} !== {my[k], mr[k], mf[k], mb[k]}) begin
            n_err++;
            $display("FAIL model_dut%0d t=%0t got Y/RISE/FALL/BUSY=%b%b%b%b want %b%b%b%b",
                     k, $time, y, r, f, b, my[k], mr[k], mf[k], mb[k]);
        end
    endtask

    always @(negedge clk) begin
        cmp(0, Y0, RISE0, FALL0, BUSY0);
        cmp(1, Y1, RISE1, FALL1, BUSY1);
        if (!rst1 && (RISE1 || FALL1)) nstrobe1++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    initial begin
        int nb, nr, nf, ny, rk, fk, ns0, tog;
        rst0 = 1'b1; rst1 = 1'b1; A0 = 1'b1; A1 = 1'b0;

        // reset holds outputs low even with A high
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_outputs", {Y0, RISE0, FALL0, BUSY0}, 0);
        end
        A0 = 1'b0; rst0 = 1'b0;
        repeat (4) @(negedge clk);

        // 5-sample glitch: BUSY for 5 cycles, no level change
        nb = 0; nr = 0; ny = 0;
        A0 = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (k == 4) A0 = 1'b0;
            nb += BUSY0; nr += RISE0; ny += Y0;
        end
        chk("glitch_busy_cycles", nb, 5);
        chk("glitch_rise", nr, 0);
        chk("glitch_y", ny, 0);
        chk("glitch_idle", BUSY0, 0);

        // clean rise: A set before edge N, RISE after edge N+9
        A0 = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            chk("rise_busy", BUSY0, (k >= 2 && k <= 8));
            chk("rise_strobe", RISE0, (k == 9));
            chk("rise_y", Y0, (k >= 9));
        end
        A0 = 1'b0;
        repeat (14) @(negedge clk);
        chk("fall_back_y", Y0, 0);

        // 7 samples: rejected at the boundary
        nr = 0; ny = 0;
        A0 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 6) A0 = 1'b0;
            nr += RISE0; ny += Y0;
        end
        chk("b7_rise", nr, 0);
        chk("b7_y", ny, 0);

        // 8 samples: accepted, one RISE then one FALL
        nr = 0; nf = 0;
        A0 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 7) A0 = 1'b0;
            nr += RISE0; nf += FALL0;
        end
        chk("b8_rise_cycles", nr, 1);
        chk("b8_fall_cycles", nf, 1);

        // async reset in PEND_LO with cnt=5
        A0 = 1'b1;
        repeat (12) @(negedge clk);
        A0 = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_y", Y0, 1);
        chk("pre_rst_busy", BUSY0, 1);
        #2 rst0 = 1'b1;
        #1;
        chk("async_rst_y", Y0, 0);
        chk("async_rst_busy", BUSY0, 0);
        chk("async_rst_strobes", {RISE0, FALL0}, 0);
        A0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        rk = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (RISE0 && rk == 0) rk = k;
        end
        chk("post_rst_rise_edge", rk, 10);

        // RESET_LEVEL=1 instance, A low through release
        @(negedge clk);
        rst1 = 1'b0;
        chk("rl1_y_out_of_reset", Y1, 1);
        fk = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (FALL1 && fk == 0) fk = k;
        end
        chk("rl1_fall_edge", fk, 6);
        chk("rl1_y_low", Y1, 0);

        ns0 = nstrobe1; tog = 0;
        for (int t = 0; t < 10; t++) begin
            A1 = ~A1;
            tog++;
            repeat (20 + $urandom_range(0, 6)) @(negedge clk);
            chk("rl1_y_follows_a", Y1, A1);
            chk("rl1_strobe_count", nstrobe1 - ns0, tog);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
